// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the bus, decodes
// 11-bit frames (start, 8 data LSB first, odd parity, stop) into a FWFT byte FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8,
    parameter int PARITY_CHECK   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    output logic [7:0]                      rd_data,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic                            frame_err,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s;
    logic          data_s;
    logic          filt_clk;
    logic          filt_prev;
    logic [3:0]    filt_cnt;
    logic          strobe;

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt;
    logic          parity_acc;
    logic          parity_ok;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit;
    logic          push;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic [7:0]    last_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // Synchronizers and filter reset to 1 so an idle bus produces no spurious falling edge.
    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt_prev <= filt_clk;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == 4'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 4'd1;
            end
        end
    end

    assign strobe      = filt_prev & ~filt_clk;
    assign timeout_hit = (state_q != IDLE) && !strobe && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: defaults first so no path through this block leaves an output unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE:    if (strobe && !data_s) state_d = DATA;
            DATA:    if (strobe && bit_cnt == 3'd7) state_d = PARITY;
            PARITY:  if (strobe) state_d = STOP;
            STOP: begin
                if (strobe) begin
                    state_d = IDLE;
                    if (data_s && parity_ok) push = 1'b1;
                    else                     frame_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout_hit) begin
            state_d   = IDLE;
            frame_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            parity_acc <= 1'b0;
            parity_ok  <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            if (strobe) begin
                case (state_q)
                    IDLE: begin
                        bit_cnt    <= '0;
                        parity_acc <= 1'b0;
                    end
                    DATA: begin
                        shift_q    <= {data_s, shift_q[7:1]};
                        parity_acc <= parity_acc ^ data_s;
                        bit_cnt    <= bit_cnt + 3'd1;
                    end
                    PARITY: parity_ok <= (PARITY_CHECK != 0) ? (parity_acc ^ data_s) : 1'b1;
                    default: ;
                endcase
            end
            if (strobe || state_d == IDLE) tmo_cnt <= '0;
            else                           tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == LW'(FIFO_DEPTH));
    assign pop      = rd_ready && !empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign wr_en    = push && (!full || pop);
    assign overflow = push && full && !pop;
    assign rd_valid = !empty;
    assign rd_data  = empty ? last_q : mem[rd_ptr];
    assign level    = count;

    // NOTE: the storage array carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            if (wr_en && !pop)      count <= count + LW'(1);
            else if (pop && !wr_en) count <= count - LW'(1);
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a frame table plus hand sequences for timeout,
// glitch rejection, overflow, full-with-pop, parity disable and mid-frame reset.
module tb_ps2_rx_fifo;

    localparam int FL    = 4;
    localparam int TMO   = 200;
    localparam int DEPTH = 4;
    localparam int HALF  = 20;
    localparam int LAT   = 2 + FL;  // negedges from ps2_clk fall to the strobe cycle

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_np = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_ready = 1'b0;
    logic       np_rd_ready = 1'b0;
    logic [7:0] rd_data, np_rd_data;
    logic       rd_valid, np_rd_valid;
    logic       frame_err, np_frame_err;
    logic       overflow, np_overflow;
    logic [2:0] level, np_level;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, ov_cnt = 0, np_fe_cnt = 0;
    int fe_double = 0, ov_double = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH), .PARITY_CHECK(1)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .frame_err(frame_err), .overflow(overflow), .level(level)
    );

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH), .PARITY_CHECK(0)) dut_np (
        .clk(clk), .rst(rst_np), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_data(np_rd_data), .rd_valid(np_rd_valid), .rd_ready(np_rd_ready),
        .frame_err(np_frame_err), .overflow(np_overflow), .level(np_level)
    );

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overflow) ov_cnt++;
        if (np_frame_err) np_fe_cnt++;
        if (frame_err && fe_prev) fe_double++;
        if (overflow && ov_prev) ov_double++;
        fe_prev = frame_err;
        ov_prev = overflow;
    end

    typedef struct {
        logic [7:0] data;
        bit         par_flip;
        bit         stop_bit;
        bit         exp_push;
        bit         exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input bit glitch);
        ps2_data = b;
        wait_cyc(HALF / 2);
        if (glitch) begin
            ps2_clk = 1'b0;
            wait_cyc(2);
            ps2_clk = 1'b1;
        end
        wait_cyc(HALF / 2);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    // Start, 8 data bits, parity; the stop bit is left to the caller.
    task automatic send_head(input logic [7:0] d, input bit par_flip, input int glitch_bit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch_bit == i);
        send_bit((~^d) ^ par_flip, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_bit, input int glitch_bit);
        send_head(d, par_flip, glitch_bit);
        send_bit(stop_bit, 1'b0);
        wait_cyc(4);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    initial begin
        int fe0, ov0, np0, c;
        bit got;
        logic [7:0] exp_b;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1};

        wait_cyc(3);
        check("reset_rd_data", rd_data, 8'h00);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overflow", overflow, 0);
        check("reset_level", level, 0);
        rst = 1'b0;
        wait_cyc(5);

        for (int v = 0; v < 7; v++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send_frame(vecs[v].data, vecs[v].par_flip, vecs[v].stop_bit, -1);
            check($sformatf("vec%0d_err", v), fe_cnt - fe0, vecs[v].exp_err);
            check($sformatf("vec%0d_ovf", v), ov_cnt - ov0, 0);
            check($sformatf("vec%0d_level", v), level, vecs[v].exp_push);
            check($sformatf("vec%0d_valid", v), rd_valid, vecs[v].exp_push);
            if (vecs[v].exp_push) begin
                check($sformatf("vec%0d_data", v), rd_data, vecs[v].data);
                pop_one();
                check($sformatf("vec%0d_hold", v), rd_data, vecs[v].data);
            end
            rd_ready = 1'b1;
            wait_cyc(2);
            rd_ready = 1'b0;
            check($sformatf("vec%0d_empty_level", v), level, 0);
        end

        // Parity checking disabled: the bad-parity frame is accepted by the second instance only.
        rst_np = 1'b0;
        wait_cyc(3);
        fe0 = fe_cnt;
        np0 = np_fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        check("np_valid", np_rd_valid, 1);
        check("np_data", np_rd_data, 8'h1C);
        check("np_level", np_level, 1);
        check("np_no_err", np_fe_cnt - np0, 0);
        check("pc_err", fe_cnt - fe0, 1);
        check("pc_level", level, 0);
        rst_np = 1'b1;

        // Glitch rejection during DATA.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, 3);
        check("glitch_err", fe_cnt - fe0, 0);
        check("glitch_level", level, 1);
        check("glitch_data", rd_data, 8'h3C);
        pop_one();

        // Timeout on a partial frame, then a clean 0xF0.
        fe0 = fe_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        c = 0;
        got = 1'b0;
        while (c < 2 * TMO + 100 && !got) begin
            @(negedge clk);
            c++;
            if (c == HALF) ps2_clk = 1'b1;
            if (frame_err) got = 1'b1;
        end
        check("timeout_seen", got, 1);
        check("timeout_latency", c, LAT + TMO);
        ps2_clk = 1'b1;
        wait_cyc(4);
        check("timeout_pulses", fe_cnt - fe0, 1);
        check("timeout_level", level, 0);
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        check("after_tmo_level", level, 1);
        check("after_tmo_data", rd_data, 8'hF0);
        pop_one();

        // Overflow: five bytes into a depth-4 FIFO, then drain in order.
        ov0 = ov_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1, -1);
        check("fill_level", level, 4);
        check("fill_no_ovf", ov_cnt - ov0, 0);
        send_frame(8'h05, 1'b0, 1'b1, -1);
        check("ovf_pulse", ov_cnt - ov0, 1);
        check("ovf_level", level, 4);
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'(i + 1);
            check($sformatf("drain%0d_data", i), rd_data, exp_b);
            pop_one();
        end
        check("drain_level", level, 0);
        check("drain_valid", rd_valid, 0);

        // Full FIFO with a pop in the very cycle of the push.
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1, -1);
        ov0 = ov_cnt;
        send_head(8'h15, 1'b0, -1);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(LAT);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(4);
        check("fullpop_level", level, 4);
        check("fullpop_no_ovf", ov_cnt - ov0, 0);
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h12 + 8'(i);
            check($sformatf("fullpop%0d_data", i), rd_data, exp_b);
            pop_one();
        end
        check("fullpop_empty", level, 0);

        // Reset in the middle of a frame.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rst = 1'b1;
        wait_cyc(3);
        check("midrst_rd_data", rd_data, 8'h00);
        check("midrst_level", level, 0);
        rst = 1'b0;
        wait_cyc(4);
        fe0 = fe_cnt;
        send_frame(8'h77, 1'b0, 1'b1, -1);
        check("postrst_level", level, 1);
        check("postrst_data", rd_data, 8'h77);
        check("postrst_err", fe_cnt - fe0, 0);
        pop_one();

        check("frame_err_single", fe_double, 0);
        check("overflow_single", ov_double, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: consecutive equal clk samples needed before the filtered ps2_clk changes; legal range 1-15.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: clk cycles without a bit strobe before a partial frame is aborted.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: received-byte buffer depth; power of two, at least 2.
REQ-004 SHALL have parameter PARITY_CHECK, default 1: 1 enforces odd parity, 0 ignores the parity bit.
REQ-005 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-008 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-009 SHALL have port rd_data  output  8  FIFO head byte; valid while rd_valid=1.
REQ-010 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-011 SHALL have port rd_ready  input  1  consumer accept; pop when rd_valid & rd_ready.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout failure.
REQ-013 SHALL have port overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-014 SHALL have port level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-015 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-016 SHALL change the filtered clock only after FILTER_LEN consecutive synchronized samples equal the new value; shorter pulses have no effect.
REQ-017 SHALL generate a one-cycle strobe on each 1->0 transition of the filtered clock and sample synchronized ps2_data in that cycle.
REQ-018 SHALL implement states IDLE, DATA, PARITY, STOP; all transitions happen only on a strobe, except timeout.
REQ-019 IDLE: strobe with data=0 (start bit) -> DATA, bit counter=0, parity accumulator=0; strobe with data=1 -> stay IDLE, no error.
REQ-020 DATA: shift sampled bit into bit 7 of the shift register (LSB first), XOR into the accumulator, increment the counter; after the 8th bit -> PARITY.
REQ-021 PARITY: latch parity_ok = (accumulator XOR sampled bit)==1, or 1 when PARITY_CHECK=0; -> STOP.
REQ-022 STOP: sampled data=1 and parity_ok -> push byte; otherwise frame_err pulse and no push; -> IDLE in all cases.
REQ-023 SHALL count clk cycles since the last strobe while not in IDLE; on reaching TIMEOUT_CYCLES -> IDLE, pulse frame_err, discard the partial byte, no push.
REQ-024 SHALL reset the timeout counter on every strobe and hold it at 0 in IDLE.
REQ-025 SHALL push on the clock edge ending the stop-bit strobe cycle; rd_valid=1 and the byte on rd_data from the next cycle.
REQ-026 SHALL present rd_data first-word-fall-through; bytes are popped in arrival order.
REQ-027 When full: push without a same-cycle pop -> byte dropped, overflow pulse, FIFO unchanged.
REQ-028 When full: push with a same-cycle pop -> both succeed, level unchanged, no overflow.
REQ-029 When empty: rd_ready ignored, level stays 0, rd_data holds its last value.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; level SHALL reach FIFO_DEPTH exactly.
REQ-031 frame_err and overflow SHALL never be asserted for more than one consecutive cycle per event.

Reset
REQ-032 While rst=1, all outputs SHALL be 0: rd_data=0x00, rd_valid=0, frame_err=0, overflow=0, level=0.
REQ-033 Reset SHALL set synchronizers and filtered clock to 1 (bus idle), state IDLE, all counters and pointers 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; the first complete frame after release SHALL be received correctly.

Verification
REQ-035 Frame 0x1C, parity 0, stop 1, clock ~10 kHz -> one push, rd_data=0x1C, rd_valid=1, level=1, no frame_err.
REQ-036 Frame 0x1C with parity 1 -> frame_err single pulse after the stop strobe, level stays 0; PARITY_CHECK=0 -> byte 0x1C accepted.
REQ-037 Start bit plus 3 data bits, then ps2_clk held high -> frame_err exactly TIMEOUT_CYCLES after the last strobe; a following 0xF0 frame (parity 1) is received intact.
REQ-038 FIFO_DEPTH=4, rd_ready=0, send 0x01-0x05 -> level=4, one overflow pulse on the 5th byte; draining yields 0x01-0x04 in order.
REQ-039 FILTER_LEN=4, 2-cycle low glitch on ps2_clk during DATA -> no extra bit sampled; the frame completes with the correct byte.
REQ-040 Full FIFO, pop asserted in the same cycle as a new push -> level unchanged, no overflow, new byte last in order.
